// File: rtl/rv32v_mem_lane_sequencer_if.sv
// Request and load/store-controller bundle for rv32v_mem_lane_sequencer.
// master = uop source plus LSC model, slave = the sequencer itself.
interface rv32v_mem_lane_sequencer_if #(
  parameter int NUM_LANES   = 4,
  parameter int BLOCK_WORDS = 2
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_wen;
  logic                       req_ren;
  logic [1:0]                 req_eew;
  logic                       req_unit;
  logic [NUM_LANES-1:0]       req_mask;
  logic [NUM_LANES*32-1:0]    req_addr;
  logic [NUM_LANES*32-1:0]    req_wdata;
  logic                       lsc_wen;
  logic                       lsc_ren;
  logic [31:0]                lsc_addr;
  logic [BLOCK_WORDS*32-1:0]  lsc_wdata;
  logic [BLOCK_WORDS*4-1:0]   lsc_byte_en;
  logic                       lsc_ready;
  logic [BLOCK_WORDS*32-1:0]  lsc_rdata;
  logic                       done;
  logic [NUM_LANES*32-1:0]    load_data;
  logic [NUM_LANES-1:0]       lane_fault;

  modport master (
    output req_valid, req_wen, req_ren, req_eew, req_unit, req_mask, req_addr, req_wdata,
    input  req_ready,
    input  lsc_wen, lsc_ren, lsc_addr, lsc_wdata, lsc_byte_en,
    output lsc_ready, lsc_rdata,
    input  done, load_data, lane_fault
  );

  modport slave (
    input  req_valid, req_wen, req_ren, req_eew, req_unit, req_mask, req_addr, req_wdata,
    output req_ready,
    output lsc_wen, lsc_ren, lsc_addr, lsc_wdata, lsc_byte_en,
    input  lsc_ready, lsc_rdata,
    output done, load_data, lane_fault
  );
endinterface

// File: rtl/rv32v_mem_lane_sequencer.sv
// Vector memory serializer: walks the active, aligned lanes of one uop and issues one LSC beat each.
// Define RV32V_SERIAL_COALESCE_EN to merge unit-strided eew32 lanes that share a dcache block into one beat.
module rv32v_mem_lane_sequencer #(
  parameter int NUM_LANES   = 4,
  parameter int BLOCK_WORDS = 2
) (
  input logic                       CLK,
  input logic                       nRST,
  rv32v_mem_lane_sequencer_if.slave bus
);
  localparam int BW_LOG = $clog2(BLOCK_WORDS);
  localparam int SLOT_W = (BLOCK_WORDS > 1) ? BW_LOG : 1;
  localparam int BE_W   = BLOCK_WORDS * 4;
  localparam int BD_W   = BLOCK_WORDS * 32;
  localparam int LD_W   = NUM_LANES * 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic misaligned(input logic [1:0] eew, input logic [31:0] a);
    case (eew)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      default: misaligned = (a[1:0] != 2'b00);
    endcase
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(input logic [31:0] a);
    slot_of = SLOT_W'((a >> 2) & 32'(BLOCK_WORDS - 1));
  endfunction

  // Lowest pending lane leads; with coalescing, later pending lanes in the same block join it.
  function automatic logic [NUM_LANES-1:0] beat_set(input logic [NUM_LANES-1:0] pend,
                                                    input logic [LD_W-1:0]      addrs,
                                                    input logic                 coal);
    logic        found;
    logic [31:0] base;
    beat_set = {NUM_LANES{1'b0}};
    found    = 1'b0;
    base     = 32'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (pend[i] && !found) begin
        beat_set[i] = 1'b1;
        found       = 1'b1;
        base        = addrs[i*32 +: 32];
      end else if (pend[i] && coal &&
                   ((addrs[i*32 +: 32] >> (BW_LOG + 2)) == (base >> (BW_LOG + 2)))) begin
        beat_set[i] = 1'b1;
      end else begin
        beat_set[i] = 1'b0;
      end
    end
  endfunction

  function automatic logic [31:0] lead_word(input logic [NUM_LANES-1:0] set,
                                            input logic [LD_W-1:0]      addrs);
    lead_word = 32'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (set[i]) lead_word = {addrs[i*32+2 +: 30], 2'b00};
    end
  endfunction

  function automatic logic [BE_W-1:0] beat_be(input logic [NUM_LANES-1:0] set,
                                              input logic [LD_W-1:0]      addrs,
                                              input logic [1:0]           eew);
    logic [31:0] a;
    logic [3:0]  be4;
    beat_be = {BE_W{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      a = addrs[i*32 +: 32];
      case (eew)
        2'b00:   be4 = 4'b0001 << a[1:0];
        2'b01:   be4 = 4'b0011 << {a[1], 1'b0};
        default: be4 = 4'b1111;
      endcase
      if (set[i]) beat_be = beat_be | (BE_W'(be4) << {slot_of(a), 2'b00});
    end
  endfunction

  function automatic logic [BD_W-1:0] beat_wdata(input logic [NUM_LANES-1:0] set,
                                                 input logic [LD_W-1:0]      addrs,
                                                 input logic [LD_W-1:0]      wdatas,
                                                 input logic [1:0]           eew);
    logic [31:0] d;
    logic [31:0] rep;
    beat_wdata = {BD_W{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      d = wdatas[i*32 +: 32];
      case (eew)
        2'b00:   rep = {4{d[7:0]}};
        2'b01:   rep = {2{d[15:0]}};
        default: rep = d;
      endcase
      if (set[i]) beat_wdata = beat_wdata | (BD_W'(rep) << {slot_of(addrs[i*32 +: 32]), 5'b00000});
    end
  endfunction

  function automatic logic [31:0] lane_load(input logic [BD_W-1:0] rdata,
                                            input logic [31:0]     a,
                                            input logic [1:0]      eew);
    logic [31:0] word;
    word = 32'(rdata >> {slot_of(a), 5'b00000});
    word = word >> {a[1:0], 3'b000};
    case (eew)
      2'b00:   lane_load = {24'd0, word[7:0]};
      2'b01:   lane_load = {16'd0, word[15:0]};
      default: lane_load = word;
    endcase
  endfunction

  logic [1:0]           state_r, state_nxt_s;
  logic                 wen_r, wen_nxt_s;
  logic [1:0]           eew_r, eew_nxt_s;
  logic [LD_W-1:0]      addr_r, addr_nxt_s;
  logic [LD_W-1:0]      wdata_r, wdata_nxt_s;
  logic [NUM_LANES-1:0] pend_r, pend_nxt_s;
  logic                 coal_r, coal_nxt_s;
  logic                 accept_s, retire_s;
  logic [NUM_LANES-1:0] ok_s, fault_s, cur_set_s, nxt_set_s;

  assign accept_s  = (state_r == ST_IDLE) & bus.req_valid & (bus.req_wen | bus.req_ren);
  assign retire_s  = (state_r == ST_ISSUE) & bus.lsc_ready;
  assign cur_set_s = beat_set(pend_r, addr_r, coal_r);
  assign nxt_set_s = beat_set(pend_nxt_s, addr_nxt_s, coal_nxt_s);

`ifdef RV32V_SERIAL_COALESCE_EN
  assign coal_nxt_s = accept_s ? (bus.req_unit & bus.req_eew[1]) : coal_r;

  // Coalescing qualifier latched with the uop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) coal_r <= 1'b0;
    else       coal_r <= coal_nxt_s;
  end
`else
  assign coal_nxt_s = 1'b0;
  assign coal_r     = 1'b0;
`endif

  // Split each requested lane into serviceable or faulted.
  always_comb begin
    ok_s    = {NUM_LANES{1'b0}};
    fault_s = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      fault_s[i] = bus.req_mask[i] & misaligned(bus.req_eew, bus.req_addr[i*32 +: 32]);
      ok_s[i]    = bus.req_mask[i] & ~misaligned(bus.req_eew, bus.req_addr[i*32 +: 32]);
    end
  end

  // Next-state and uop latch selection.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    wen_nxt_s   = wen_r;
    eew_nxt_s   = eew_r;
    addr_nxt_s  = addr_r;
    wdata_nxt_s = wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          wen_nxt_s   = bus.req_wen;
          eew_nxt_s   = bus.req_eew;
          addr_nxt_s  = bus.req_addr;
          wdata_nxt_s = bus.req_wdata;
          pend_nxt_s  = ok_s;
          state_nxt_s = (ok_s == {NUM_LANES{1'b0}}) ? ST_DONE : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (retire_s) begin
          pend_nxt_s  = pend_r & ~cur_set_s;
          state_nxt_s = ((pend_r & ~cur_set_s) == {NUM_LANES{1'b0}}) ? ST_DONE : ST_ISSUE;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state, uop latches and handshake outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r       <= ST_IDLE;
      pend_r        <= {NUM_LANES{1'b0}};
      wen_r         <= 1'b0;
      eew_r         <= 2'b00;
      addr_r        <= {LD_W{1'b0}};
      wdata_r       <= {LD_W{1'b0}};
      bus.req_ready <= 1'b1;
      bus.done      <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pend_r        <= pend_nxt_s;
      wen_r         <= wen_nxt_s;
      eew_r         <= eew_nxt_s;
      addr_r        <= addr_nxt_s;
      wdata_r       <= wdata_nxt_s;
      bus.req_ready <= (state_nxt_s == ST_IDLE);
      bus.done      <= (state_nxt_s == ST_DONE);
    end
  end

  // Beat outputs come from next-state values, so they are registered and hold across a stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.lsc_wen     <= 1'b0;
      bus.lsc_ren     <= 1'b0;
      bus.lsc_addr    <= 32'd0;
      bus.lsc_byte_en <= {BE_W{1'b0}};
      bus.lsc_wdata   <= {BD_W{1'b0}};
    end else if (state_nxt_s == ST_ISSUE) begin
      bus.lsc_wen     <= wen_nxt_s;
      bus.lsc_ren     <= ~wen_nxt_s;
      bus.lsc_addr    <= lead_word(nxt_set_s, addr_nxt_s);
      bus.lsc_byte_en <= beat_be(nxt_set_s, addr_nxt_s, eew_nxt_s);
      bus.lsc_wdata   <= beat_wdata(nxt_set_s, addr_nxt_s, wdata_nxt_s, eew_nxt_s);
    end else begin
      bus.lsc_wen     <= 1'b0;
      bus.lsc_ren     <= 1'b0;
      bus.lsc_addr    <= 32'd0;
      bus.lsc_byte_en <= {BE_W{1'b0}};
      bus.lsc_wdata   <= {BD_W{1'b0}};
    end
  end

  // Per-lane results: cleared on accept, filled as load beats retire.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.load_data  <= {LD_W{1'b0}};
      bus.lane_fault <= {NUM_LANES{1'b0}};
    end else if (accept_s) begin
      bus.load_data  <= {LD_W{1'b0}};
      bus.lane_fault <= fault_s;
    end else if (retire_s && !wen_r) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (cur_set_s[i]) bus.load_data[i*32 +: 32] <= lane_load(bus.lsc_rdata, addr_r[i*32 +: 32], eew_r);
      end
    end
  end
endmodule

// File: tb/tb_rv32v_mem_lane_sequencer.sv
// Scoreboard bench for rv32v_mem_lane_sequencer: a byte-level model predicts beats and lane results.
module tb_rv32v_mem_lane_sequencer;
  localparam int NL = 4;
  localparam int BW = 2;
`ifdef RV32V_SERIAL_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  typedef struct {
    logic             wen;
    logic [31:0]      addr;
    logic [BW*4-1:0]  be;
    logic [BW*32-1:0] wd;
    bit               last;
  } beat_t;

  typedef struct {
    int               nbeats;
    logic [NL*32-1:0] ld;
    logic [NL-1:0]    fault;
  } res_t;

  logic clk = 1'b0;
  logic nrst;
  int   checks = 0;
  int   errors = 0;
  bit   rdy_force = 1'b0;
  bit   rdy_val = 1'b1;
  bit   mon_en = 1'b0;
  beat_t beat_q[$];
  res_t  res_q[$];
  logic [31:0] rd_base;

  rv32v_mem_lane_sequencer_if #(.NUM_LANES(NL), .BLOCK_WORDS(BW)) bus_if ();
  rv32v_mem_lane_sequencer #(.NUM_LANES(NL), .BLOCK_WORDS(BW)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memb(input logic [31:0] a);
    logic [31:0] h;
    h = a * 32'd2654435761;
    memb = h[31:24] ^ a[7:0];
  endfunction

  always_comb begin
    rd_base = bus_if.lsc_addr & ~32'(BW*4 - 1);
    bus_if.lsc_rdata = '0;
    for (int p = 0; p < BW*4; p++) bus_if.lsc_rdata[p*8 +: 8] = memb(rd_base + 32'(p));
  end

  always @(posedge clk) begin
    #1;
    bus_if.lsc_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: bytes touched per lane, beats in lane order, block grouping only when coalescing.
  task automatic issue(input bit wen, input bit ren, input logic [1:0] eew, input bit unit,
                       input logic [NL-1:0] mask, input logic [NL*32-1:0] addrs,
                       input logic [NL*32-1:0] wds);
    int n, s, pos, w;
    int pend[$];
    int grp[$];
    logic [31:0] a, lead;
    beat_t b;
    res_t  r;
    if (wen || ren) begin
      n = (eew == 2'd0) ? 1 : (eew == 2'd1) ? 2 : 4;
      r.nbeats = 0; r.ld = '0; r.fault = '0;
      for (int i = 0; i < NL; i++) begin
        if (mask[i]) begin
          a = addrs[i*32 +: 32];
          if (int'(a % 32'(n)) != 0) r.fault[i] = 1'b1;
          else begin
            pend.push_back(i);
            if (!wen) for (int k = 0; k < n; k++) r.ld[i*32 + 8*k +: 8] = memb(a + 32'(k));
          end
        end
      end
      while (pend.size() > 0) begin
        lead = addrs[pend[0]*32 +: 32];
        grp.delete();
        grp.push_back(pend[0]);
        pend.delete(0);
        if (COAL && unit && n == 4) begin
          w = 0;
          while (w < pend.size()) begin
            if (addrs[pend[w]*32 +: 32] / 32'(BW*4) == lead / 32'(BW*4)) begin
              grp.push_back(pend[w]);
              pend.delete(w);
            end else w++;
          end
        end
        b.wen = wen; b.addr = lead & ~32'd3; b.be = '0; b.wd = '0;
        foreach (grp[g]) begin
          a = addrs[grp[g]*32 +: 32];
          s = int'((a / 32'd4) % 32'(BW));
          pos = int'(a % 32'(BW*4));
          for (int k = 0; k < n; k++) b.be[pos + k] = 1'b1;
          for (int j = 0; j < 4; j++) b.wd[(s*4 + j)*8 +: 8] = wds[grp[g]*32 + (j % n)*8 +: 8];
        end
        b.last = (pend.size() == 0);
        beat_q.push_back(b);
        r.nbeats++;
      end
      res_q.push_back(r);
    end
    bus_if.req_valid = 1'b1; bus_if.req_wen = wen; bus_if.req_ren = ren; bus_if.req_eew = eew;
    bus_if.req_unit = unit; bus_if.req_mask = mask; bus_if.req_addr = addrs; bus_if.req_wdata = wds;
    if (wen || ren) begin
      w = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (bus_if.req_ready) begin w = 1; break; end
      end
      if (w == 0) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got req_ready=0 expected 1 within 300 cycles");
      end
      @(posedge clk); #1;
    end else begin
      repeat (3) @(posedge clk);
      #1;
    end
    bus_if.req_valid = 1'b0;
  endtask

  // Monitor: retires beats against the queue, checks stall stability, done timing and results.
  bit acc_pending = 0, done_due = 0, stall_prev = 0, done_prev = 0;
  logic [31:0] h_addr; logic [BW*4-1:0] h_be; logic [BW*32-1:0] h_wd; logic h_wen, h_ren;
  always @(negedge clk) begin
    bit exp_done;
    beat_t b;
    res_t r;
    if (mon_en) begin
      exp_done = done_due;
      done_due = 0;
      if (done_prev) chk("req_ready_after_done", bus_if.req_ready, 1'b1);
      if (acc_pending) begin
        acc_pending = 0;
        if (res_q.size() == 0) begin
          checks++; errors++; $display("FAIL accept_unexpected: got accept expected none");
        end else if (res_q[0].nbeats == 0) exp_done = 1;
        else chk("first_beat_latency", bus_if.lsc_wen | bus_if.lsc_ren, 1'b1);
      end
      if (bus_if.lsc_wen || bus_if.lsc_ren) begin
        chk("req_ready_busy", bus_if.req_ready, 1'b0);
        if (stall_prev) chk("stall_stable", {h_wen, h_ren, h_addr, h_be, h_wd},
                            {bus_if.lsc_wen, bus_if.lsc_ren, bus_if.lsc_addr, bus_if.lsc_byte_en, bus_if.lsc_wdata});
        if (bus_if.lsc_ready) begin
          stall_prev = 0;
          if (beat_q.size() == 0) begin
            checks++; errors++; $display("FAIL beat_unexpected: got beat addr %0h expected none", bus_if.lsc_addr);
          end else begin
            b = beat_q.pop_front();
            chk("beat_wen", bus_if.lsc_wen, b.wen);
            chk("beat_ren", bus_if.lsc_ren, !b.wen);
            chk("beat_addr", bus_if.lsc_addr, b.addr);
            chk("beat_byte_en", bus_if.lsc_byte_en, b.be);
            if (b.wen) chk("beat_wdata", bus_if.lsc_wdata, b.wd);
            if (b.last) done_due = 1;
          end
        end else begin
          stall_prev = 1;
          h_wen = bus_if.lsc_wen; h_ren = bus_if.lsc_ren; h_addr = bus_if.lsc_addr;
          h_be = bus_if.lsc_byte_en; h_wd = bus_if.lsc_wdata;
        end
      end else stall_prev = 0;
      chk("done_timing", bus_if.done, exp_done);
      if (bus_if.done) begin
        chk("req_ready_in_done", bus_if.req_ready, 1'b0);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          chk("load_data", bus_if.load_data, r.ld);
          chk("lane_fault", bus_if.lane_fault, r.fault);
        end
      end
      done_prev = bus_if.done;
      if (bus_if.req_valid && bus_if.req_ready && (bus_if.req_wen || bus_if.req_ren)) acc_pending = 1;
    end
  end

  initial begin
    logic [NL*32-1:0] ad, wd;
    logic [31:0] base, a;
    logic [1:0] eew;
    bit unit;
    int n;
    bus_if.req_valid = 0; bus_if.req_wen = 0; bus_if.req_ren = 0; bus_if.req_eew = 0;
    bus_if.req_unit = 0; bus_if.req_mask = 0; bus_if.req_addr = 0; bus_if.req_wdata = 0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus_if.req_ready, 1'b1);
    chk("rst_strobes", {bus_if.lsc_wen, bus_if.lsc_ren, bus_if.done}, 3'b000);
    chk("rst_lsc_addr", bus_if.lsc_addr, 32'd0);
    chk("rst_results", {bus_if.load_data, bus_if.lane_fault}, '0);
    @(posedge clk); #1; nrst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    rdy_force = 1; rdy_val = 1;
    issue(0, 1, 2'b10, 1, 4'b1111, {32'h10C, 32'h108, 32'h104, 32'h100}, '0);
    issue(1, 0, 2'b00, 0, 4'b0101, {32'h0, 32'h211, 32'h0, 32'h203}, {32'h0, 32'hCD, 32'h0, 32'hAB});
    issue(0, 1, 2'b01, 0, 4'b1111, {32'h306, 32'h301, 32'h302, 32'h300}, '0);
    issue(1, 0, 2'b10, 0, 4'b0000, {32'h40C, 32'h408, 32'h404, 32'h400}, '1);
    issue(0, 0, 2'b10, 0, 4'b1111, {32'h40C, 32'h408, 32'h404, 32'h400}, '1);
    issue(0, 1, 2'b10, 0, 4'b0011, {32'h0, 32'h0, 32'h502, 32'h501}, '0);
    issue(1, 1, 2'b11, 1, 4'b1011, {32'h61C, 32'h618, 32'h614, 32'h610}, {32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00});
    rdy_force = 0;

    for (int t = 0; t < 150; t++) begin
      eew = 2'($urandom_range(0, 3));
      unit = 1'($urandom_range(0, 1));
      n = (eew == 2'd0) ? 1 : (eew == 2'd1) ? 2 : 4;
      base = 32'($urandom_range(0, 32'hFFF)) << 4;
      for (int i = 0; i < NL; i++) begin
        if (unit) a = base + 32'(i * n);
        else a = base + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) & ~32'(n - 1));
        if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
        ad[i*32 +: 32] = a;
        wd[i*32 +: 32] = $urandom;
      end
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), eew, unit, 4'($urandom_range(0, 15)), ad, wd);
    end

    for (int c = 0; c < 3000 && (beat_q.size() != 0 || res_q.size() != 0); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_beats", 128'(beat_q.size()), 128'd0);
    chk("drain_results", 128'(res_q.size()), 128'd0);

    // Stall on the second beat, then abort with reset.
    mon_en = 1'b0;
    rdy_force = 1; rdy_val = 1;
    @(posedge clk); #1;
    bus_if.req_valid = 1; bus_if.req_wen = 1; bus_if.req_ren = 0; bus_if.req_eew = 2'b10;
    bus_if.req_unit = 0; bus_if.req_mask = 4'b1111;
    bus_if.req_addr = {32'h40C, 32'h408, 32'h404, 32'h400}; bus_if.req_wdata = {4{32'hA5A5_0F0F}};
    @(negedge clk);
    chk("abort_ready_before", bus_if.req_ready, 1'b1);
    @(posedge clk); #1;
    bus_if.req_valid = 0;
    rdy_val = 0;
    @(negedge clk);
    chk("abort_beat1_addr", bus_if.lsc_addr, 32'h400);
    @(negedge clk);
    h_addr = bus_if.lsc_addr; h_be = bus_if.lsc_byte_en; h_wd = bus_if.lsc_wdata; h_wen = bus_if.lsc_wen;
    chk("abort_beat2_addr", h_addr, 32'h404);
    chk("abort_beat2_be", h_be, 8'hF0);
    chk("abort_beat2_wen", h_wen, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_stall_stable", {bus_if.lsc_wen, bus_if.lsc_addr, bus_if.lsc_byte_en, bus_if.lsc_wdata},
          {1'b1, 32'h404, 8'hF0, {32'hA5A5_0F0F, 32'h0}});
    end
    #2; nrst = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {bus_if.lsc_wen, bus_if.lsc_ren, bus_if.done}, 3'b000);
    chk("abort_req_ready", bus_if.req_ready, 1'b1);
    chk("abort_results", {bus_if.load_data, bus_if.lane_fault}, '0);
    @(posedge clk); #1; nrst = 1'b1;
    @(negedge clk);
    chk("abort_idle_after", {bus_if.req_ready, bus_if.lsc_wen, bus_if.lsc_ren}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
